// File: rtl/hpram_arb_pkg.sv
// Shared types and constants for the HyperRAM two-port command arbiter.
package hpram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_WAIT  = 2'd2,
    GAP      = 2'd3
  } state_e;

  typedef enum logic {
    SIDE_RD = 1'b0,
    SIDE_WR = 1'b1
  } side_e;

  localparam logic CMD_WR = 1'b1;
  localparam logic CMD_RD = 1'b0;

  localparam int unsigned TMO_W   = 16;
  localparam int unsigned STATS_W = 16;

endpackage

// File: rtl/hpram_arb_pick.sv
// Combinational round-robin selector with urgent-read override.
module hpram_arb_pick
  import hpram_arb_pkg::*;
(
  input  logic  wr_req,
  input  logic  rd_req,
  input  logic  rd_urgent,
  input  side_e last_grant,
  output logic  grant_wr,
  output logic  grant_rd
);

  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (wr_req && rd_req) begin
      if (rd_urgent || (last_grant == SIDE_WR)) grant_rd = 1'b1;
      else                                      grant_wr = 1'b1;
    end else begin
      grant_wr = wr_req;
      grant_rd = rd_req;
    end
  end

endmodule

// File: rtl/hpram_arbiter.sv
// Burst arbiter between camera write and HDMI read paths onto the HyperRAM controller.
// Optional burst counters are enabled with the HPRAM_ARB_STATS_EN macro.
module hpram_arbiter
  import hpram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 22,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BURST_BEATS = 16,
  parameter int unsigned CMD_GAP     = 4,
  parameter int unsigned RD_TIMEOUT  = 1023
) (
  input  logic                    I_dma_clk,
  input  logic                    I_rst_n,
  input  logic                    I_init_calib,
  input  logic                    I_wr_req,
  input  logic [ADDR_WIDTH-1:0]   I_wr_addr,
  output logic                    O_wr_ack,
  output logic                    O_wr_data_rd,
  input  logic [DATA_WIDTH-1:0]   I_wr_data,
  input  logic [DATA_WIDTH/8-1:0] I_wr_mask,
  input  logic                    I_rd_req,
  input  logic                    I_rd_urgent,
  input  logic [ADDR_WIDTH-1:0]   I_rd_addr,
  output logic                    O_rd_ack,
  output logic                    O_rd_data_valid,
  output logic [DATA_WIDTH-1:0]   O_rd_data,
  output logic                    O_cmd,
  output logic                    O_cmd_en,
  output logic [ADDR_WIDTH-1:0]   O_addr,
  output logic [DATA_WIDTH-1:0]   O_wr_data,
  output logic [DATA_WIDTH/8-1:0] O_data_mask,
  input  logic                    I_rd_data_valid,
  input  logic [DATA_WIDTH-1:0]   I_rd_data,
  output logic                    O_err
`ifdef HPRAM_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0]      O_wr_bursts,
  output logic [STATS_W-1:0]      O_rd_bursts
`endif
);

  localparam int unsigned BEAT_W = $clog2(BURST_BEATS + 1);
  localparam int unsigned GAP_W  = (CMD_GAP > 0) ? $clog2(CMD_GAP + 1) : 1;

  state_e              state;
  side_e               last_grant;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                grant_wr;
  logic                grant_rd;
  logic                last_beat;

  hpram_arb_pick u_pick (
    .wr_req     (I_wr_req),
    .rd_req     (I_rd_req),
    .rd_urgent  (I_rd_urgent),
    .last_grant (last_grant),
    .grant_wr   (grant_wr),
    .grant_rd   (grant_rd)
  );

  assign last_beat = (beat_cnt == BEAT_W'(BURST_BEATS - 1));

  // The IDLE arbitration cycle is the final idle cycle of the gap, so GAP itself holds CMD_GAP-1.
  function automatic state_e post_burst();
    return (CMD_GAP > 1) ? GAP : IDLE;
  endfunction

  // Zero-latency FWFT write path, only open while the burst is streaming.
  assign O_wr_data_rd = (state == WR_BURST);
  assign O_wr_data    = O_wr_data_rd ? I_wr_data : '0;
  assign O_data_mask  = O_wr_data_rd ? I_wr_mask : '0;

  always_ff @(posedge I_dma_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state           <= IDLE;
      last_grant      <= SIDE_RD;
      beat_cnt        <= '0;
      gap_cnt         <= '0;
      tmo_cnt         <= '0;
      O_cmd           <= CMD_RD;
      O_cmd_en        <= 1'b0;
      O_addr          <= '0;
      O_wr_ack        <= 1'b0;
      O_rd_ack        <= 1'b0;
      O_rd_data_valid <= 1'b0;
      O_rd_data       <= '0;
      O_err           <= 1'b0;
    end else begin
      O_cmd_en        <= 1'b0;
      O_wr_ack        <= 1'b0;
      O_rd_ack        <= 1'b0;
      O_rd_data_valid <= I_rd_data_valid;
      if (I_rd_data_valid) O_rd_data <= I_rd_data;
      if (I_rd_data_valid && (state != RD_WAIT)) O_err <= 1'b1;

      case (state)
        IDLE: begin
          if (I_init_calib && grant_wr) begin
            state      <= WR_BURST;
            beat_cnt   <= '0;
            last_grant <= SIDE_WR;
            O_cmd      <= CMD_WR;
            O_addr     <= I_wr_addr;
            O_cmd_en   <= 1'b1;
            O_wr_ack   <= 1'b1;
          end else if (I_init_calib && grant_rd) begin
            state      <= RD_WAIT;
            beat_cnt   <= '0;
            tmo_cnt    <= '0;
            last_grant <= SIDE_RD;
            O_cmd      <= CMD_RD;
            O_addr     <= I_rd_addr;
            O_cmd_en   <= 1'b1;
            O_rd_ack   <= 1'b1;
          end
        end
        WR_BURST: begin
          if (last_beat) begin
            state   <= post_burst();
            gap_cnt <= GAP_W'(1);
          end else begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
          end
        end
        RD_WAIT: begin
          if (I_rd_data_valid && last_beat) begin
            state   <= post_burst();
            gap_cnt <= GAP_W'(1);
          end else if (tmo_cnt == TMO_W'(RD_TIMEOUT - 1)) begin
            O_err   <= 1'b1;
            state   <= post_burst();
            gap_cnt <= GAP_W'(1);
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (I_rd_data_valid) beat_cnt <= beat_cnt + BEAT_W'(1);
          end
        end
        GAP: begin
          if (gap_cnt >= GAP_W'(CMD_GAP - 1)) state <= IDLE;
          else                                gap_cnt <= gap_cnt + GAP_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HPRAM_ARB_STATS_EN
  // Saturating command counters, stepped on the same edge that raises O_cmd_en.
  always_ff @(posedge I_dma_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_wr_bursts <= '0;
      O_rd_bursts <= '0;
    end else if ((state == IDLE) && I_init_calib) begin
      if (grant_wr) begin
        if (O_wr_bursts != {STATS_W{1'b1}}) O_wr_bursts <= O_wr_bursts + STATS_W'(1);
      end else if (grant_rd) begin
        if (O_rd_bursts != {STATS_W{1'b1}}) O_rd_bursts <= O_rd_bursts + STATS_W'(1);
      end
    end
  end
`endif

endmodule
